ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the mouse, for example 0xF4 to enable data reporting or 0xFF to reset. It is the opposite direction to the PS/2 receive path inside mouse_module. It sits in the clk100 domain beside that receiver and drives ps2_clk/ps2_data through open-drain enables; the top level builds the tristate buffers.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 states, command bytes and timing helpers
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE,
        ERR
    } ps2_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // Convert a microsecond interval into system clock cycles.
    function automatic int unsigned us_to_cycles(input int unsigned clk_freq_hz,
                                                 input int unsigned us);
        return (clk_freq_hz / 32'd1000000) * us;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop line synchronizer with falling-edge detect
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_s,
    output logic fe
);

    logic meta;
    logic prev;

    // Synchronize the raw line and keep one cycle of history; idle bus is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            line_s <= 1'b1;
            prev   <= 1'b1;
        end else begin
            meta   <= line_i;
            line_s <= meta;
            prev   <= line_s;
        end
    end

    assign fe = prev & ~line_s;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 100000000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
    input  logic       clk100,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_oe,
    input  logic       ps2_data_i,
    output logic       ps2_data_oe
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned START_CYC   = us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
    localparam int unsigned FRAME_CYC   = us_to_cycles(CLK_FREQ_HZ, FRAME_TIMEOUT_US);
    localparam int unsigned TO_MAX      = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
    localparam int unsigned MAX_CYC     = (TO_MAX > INHIBIT_CYC) ? TO_MAX : INHIBIT_CYC;
    localparam int          TIMER_W     = $clog2(MAX_CYC);

    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYC - 1);
    localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_CYC - 1);
    localparam logic [TIMER_W-1:0] FRAME_LAST   = TIMER_W'(FRAME_CYC - 1);

    ps2_state_t         state;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         bit_cnt;
    logic [9:0]         frame;
    logic               ack_ok;

    logic clk_s;
    logic clk_fe;
    logic data_s;
    logic data_fe_unused;

    ps2_line_sync u_clk_sync (
        .clk    (clk100),
        .rst_n  (rst),
        .line_i (ps2_clk_i),
        .line_s (clk_s),
        .fe     (clk_fe)
    );

    // Only the synchronized level of the data line matters; its edge output is left idle.
    ps2_line_sync u_data_sync (
        .clk    (clk100),
        .rst_n  (rst),
        .line_i (ps2_data_i),
        .line_s (data_s),
        .fe     (data_fe_unused)
    );

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Frame sequencer: inhibit, request-to-send, clock out bits on device edges, check ack.
    always_ff @(posedge clk100 or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            timer       <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            ack_ok      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        frame       <= {1'b1, ~^tx_data, tx_data};
                        timer       <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer == INHIBIT_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= START;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                START: begin
                    ps2_clk_oe <= 1'b0;
                    timer      <= '0;
                    bit_cnt    <= '0;
                    state      <= SEND;
                end
                SEND: begin
                    // Before the first edge the timer measures start latency, after it frame time.
                    if (bit_cnt != 4'd0 && timer == FRAME_LAST) begin
                        ps2_data_oe <= 1'b0;
                        state       <= ERR;
                    end else if (clk_fe) begin
                        ps2_data_oe <= ~frame[bit_cnt];
                        bit_cnt     <= bit_cnt + 4'd1;
                        timer       <= (bit_cnt == 4'd0) ? '0 : timer + 1'b1;
                        if (bit_cnt == 4'd9) begin
                            state <= ACK;
                        end
                    end else if (bit_cnt == 4'd0 && timer == START_LAST) begin
                        ps2_data_oe <= 1'b0;
                        state       <= ERR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ACK: begin
                    if (timer == FRAME_LAST) begin
                        state <= ERR;
                    end else if (clk_fe) begin
                        ack_ok <= ~data_s;
                        tx_err <= data_s;
                        state  <= WAIT_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        tx_done <= ack_ok;
                        state   <= IDLE;
                    end
                end
                ERR: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_err      <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx
module tb_ps2_host_tx;

    localparam int CLK_HZ    = 4000000;
    localparam int INH       = 400;
    localparam int START_CYC = 8000;
    localparam int H         = 160;

    logic       clk100 = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;
    logic       ps2_clk_i;
    logic       ps2_clk_oe;
    logic       ps2_data_i;
    logic       ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ      (CLK_HZ),
        .INHIBIT_US       (100),
        .START_TIMEOUT_US (2000),
        .FRAME_TIMEOUT_US (2000)
    ) dut (
        .clk100      (clk100),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_i  (ps2_data_i),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic request(input logic [7:0] b);
        @(negedge clk100);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk100);
        tx_valid = 1'b0;
    endtask

    // Issue a request, measure clock-inhibit length, wait for clock release.
    task automatic start_frame(input logic [7:0] b, output int ilen);
        int m;
        request(b);
        ilen = 0;
        while (!ps2_data_oe && ilen < 5000) begin
            cycles(1);
            ilen++;
        end
        m = 0;
        while (ps2_clk_oe && m < 10) begin
            cycles(1);
            m++;
        end
    endtask

    // Device model: 10 clock pulses sampling data on rising edges, then optional ack.
    task automatic device_frame(input int abort_after, input bit do_ack, input bit poke,
                                output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < 10; i++) begin
            cycles(H);
            dev_clk_low = 1'b1;
            if (poke && i == 5) begin
                cycles(2);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                cycles(1);
                tx_valid = 1'b0;
                cycles(H - 3);
            end else begin
                cycles(H);
            end
            dev_clk_low = 1'b0;
            bits[i] = ps2_data_i;
            if (abort_after == i + 1) return;
        end
        cycles(H / 2);
        if (do_ack) dev_data_low = 1'b1;
        cycles(H / 2);
        dev_clk_low = 1'b1;
        cycles(H);
        dev_clk_low = 1'b0;
        cycles(H / 2);
        dev_data_low = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_oe: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        vectors++;
        if ({tx_ready, busy, tx_done, tx_err} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_status: got %b expected 1000", {tx_ready, busy, tx_done, tx_err});
        end
        @(negedge clk100);
        rst = 1'b1;
        cycles(3);
        vectors++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b expected 1000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_send(input logic [7:0] b, input logic par, input bit poke);
        logic [9:0] bits;
        logic [9:0] exp_bits;
        int ilen;
        int d0;
        int e0;
        int n;
        int stray;
        exp_bits = {1'b1, par, b};
        d0 = done_cnt;
        e0 = err_cnt;
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_%h: got %b expected 1", b, tx_ready);
        end
        start_frame(b, ilen);
        vectors++;
        if (ilen != INH) begin
            miscompares++;
            $display("FAIL inhibit_len_%h: got %0d expected %0d", b, ilen, INH);
        end
        vectors++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b0101) begin
            miscompares++;
            $display("FAIL release_state_%h: got %b expected 0101", b, {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
        device_frame(0, 1'b1, poke, bits);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 2000) begin
            cycles(1);
            n++;
        end
        cycles(2);
        vectors++;
        if (bits !== exp_bits) begin
            miscompares++;
            $display("FAIL frame_bits_%h: got %b expected %b", b, bits, exp_bits);
        end
        vectors++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            miscompares++;
            $display("FAIL pulses_%h: got done=%0d err=%0d expected done=1 err=0", b, done_cnt - d0, err_cnt - e0);
        end
        vectors++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
            miscompares++;
            $display("FAIL idle_after_%h: got %b expected 1000", b, {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
        if (poke) begin
            stray = 0;
            for (int i = 0; i < 600; i++) begin
                cycles(1);
                if (ps2_clk_oe) stray++;
            end
            vectors++;
            if (stray != 0 || done_cnt - d0 != 1) begin
                miscompares++;
                $display("FAIL ignored_valid: got stray=%0d done=%0d expected stray=0 done=1", stray, done_cnt - d0);
            end
        end
    endtask

    task automatic test_nack();
        logic [9:0] bits;
        int ilen;
        int d0;
        int e0;
        int n;
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(8'hF4, ilen);
        device_frame(0, 1'b0, 1'b0, bits);
        n = 0;
        while (err_cnt == e0 && n < 2000) begin
            cycles(1);
            n++;
        end
        cycles(5);
        vectors++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            miscompares++;
            $display("FAIL nack_pulses: got err=%0d done=%0d expected err=1 done=0", err_cnt - e0, done_cnt - d0);
        end
        vectors++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
            miscompares++;
            $display("FAIL nack_idle: got %b expected 1000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_start_timeout();
        int ilen;
        int d0;
        int e0;
        int k;
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(8'hFF, ilen);
        k = 0;
        while (!tx_err && k < START_CYC + 100) begin
            cycles(1);
            k++;
        end
        vectors++;
        if (k < START_CYC || k > START_CYC + 4) begin
            miscompares++;
            $display("FAIL start_timeout_delay: got %0d expected %0d..%0d", k, START_CYC, START_CYC + 4);
        end
        cycles(3);
        vectors++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            miscompares++;
            $display("FAIL timeout_pulses: got err=%0d done=%0d expected err=1 done=0", err_cnt - e0, done_cnt - d0);
        end
        vectors++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
            miscompares++;
            $display("FAIL timeout_idle: got %b expected 1000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_reset_abort();
        logic [9:0] bits;
        int ilen;
        start_frame(8'hA5, ilen);
        device_frame(4, 1'b1, 1'b0, bits);
        cycles(H / 2);
        vectors++;
        if (ps2_data_oe !== 1'b1 || bits[3:0] !== 4'b0101) begin
            miscompares++;
            $display("FAIL abort_pre: got data_oe=%b bits=%b expected data_oe=1 bits=0101", ps2_data_oe, bits[3:0]);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        @(negedge clk100);
        rst = 1'b1;
        cycles(2);
        vectors++;
        if ({tx_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_ready: got %b expected 10", {tx_ready, busy});
        end
    endtask

    task automatic test_exclusive();
        vectors++;
        if (both_cnt != 0) begin
            miscompares++;
            $display("FAIL done_err_overlap: got %0d expected 0", both_cnt);
        end
    endtask

    initial begin
        cycles(5);
        test_reset();
        test_send(8'hF4, 1'b0, 1'b0);
        test_send(8'hFF, 1'b1, 1'b0);
        test_send(8'h00, 1'b1, 1'b0);
        test_nack();
        test_start_timeout();
        test_reset_abort();
        test_send(8'hF3, 1'b1, 1'b1);
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
